mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, memory word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, memory address width.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports req0/req1  input  1  access request per requester.
REQ-006 SHALL have ports we0/we1  input  1  1=write, 0=read, qualified by reqN.
REQ-007 SHALL have ports addr0/addr1  input  ADDR_WIDTH  access address.
REQ-008 SHALL have ports wdata0/wdata1  input  DATA_WIDTH  write data.
REQ-009 SHALL have ports gnt0/gnt1  output  1  one-cycle grant pulse.
REQ-010 SHALL have ports rvalid0/rvalid1  output  1  one-cycle read-data-valid pulse.
REQ-011 SHALL have ports rdata0/rdata1  output  DATA_WIDTH  registered read data.
REQ-012 SHALL have ports mem_addr/mem_data/mem_we  output  ADDR_WIDTH/DATA_WIDTH/1  drive one port of mem.
REQ-013 SHALL have port mem_out  input  DATA_WIDTH  read output of same mem port (registered, 1-cycle read latency).

Function
REQ-014 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; no other states.
REQ-015 IDLE: SHALL sample req0/req1 each edge; no request -> stay IDLE; any request -> select winner, register its addr/wdata/we onto mem_addr/mem_data/mem_we, go to ACCESS.
REQ-016 ACCESS: SHALL assert gntN of winner only, for exactly this one cycle; mem_we = winner's weN for this cycle only.
REQ-017 RESP: SHALL hold mem_we=0; mem_addr/mem_data hold last value.
REQ-018 On RESP->IDLE edge, for reads SHALL register rdataN<=mem_out and pulse rvalidN for one cycle; writes SHALL produce no rvalid.
REQ-019 Read latency: request sampled at edge T0 -> rvalid high during T2..T3; throughput one access per 3 cycles.
REQ-020 rdataN SHALL hold its value until the next read completing for requester N.
REQ-021 Requester SHALL keep reqN/weN/addrN/wdataN stable until gntN; inputs of the non-winner are ignored.
REQ-022 reqN still high in IDLE after its grant SHALL be treated as a new request.
REQ-023 Both requests in same IDLE cycle: round-robin, winner is requester not granted most recently; single request always wins.
REQ-024 gnt0 and gnt1 SHALL never be high simultaneously; same for rvalid0/rvalid1.

Reset
REQ-025 On reset edge: state=IDLE; gnt0/1, rvalid0/1, mem_we = 0; mem_addr, mem_data, rdata0/1 = 0; round-robin pointer set so requester 0 wins the first tie.
REQ-026 Reset during ACCESS: write already presented to memory at that edge completes; no gnt/rvalid after.
REQ-027 Reset during RESP of a read: read SHALL be dropped, no rvalid issued.
REQ-028 Reset held high SHALL override all requests.

Configuration
REQ-029 Macro ARB_FIXED_PRIO_EN defined: requester 0 SHALL win every tie; round-robin pointer not implemented.
REQ-030 ARB_FIXED_PRIO_EN undefined: round-robin per REQ-023.

Verification
REQ-031 req0 write addr 0x000 data 0xdead, then req1 write addr 0x001 data 0xbeaf -> gnt0 then gnt1 each one cycle, mem_we high only in ACCESS.
REQ-032 req0 read 0x000 and req1 read 0x001 asserted together after reset -> gnt0 first, rdata0=0xdead with rvalid0 at T2; then gnt1, rdata1=0xbeaf.
REQ-033 req0 and req1 held continuously high (reads) for 12 cycles -> grants alternate 0,1,0,1; with ARB_FIXED_PRIO_EN -> only gnt0.
REQ-034 req1 write 0x002 data 0x1234 then req0 read 0x002 -> rdata0=0x1234, rvalid1 never asserted.
REQ-035 reset asserted during RESP of req0 read -> rvalid0 stays 0, FSM IDLE, next tie granted to requester 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one registered-read memory port (IDLE -> ACCESS -> RESP).
// Define ARB_FIXED_PRIO_EN to make requester 0 win every tie instead of round-robin.
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_out
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t                  state_q, state_d;
    logic                    win_q, win_d;
    logic                    rd_q, rd_d;
    logic                    gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic                    rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_data_q, mem_data_d;
    logic [DATA_WIDTH-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic                    win_sel;

`ifdef ARB_FIXED_PRIO_EN
    assign win_sel = !req0;
`else
    logic last_q, last_d;

    // last_q is the most recently granted requester; the other one wins a tie.
    assign win_sel = (req0 && req1) ? !last_q : !req0;
`endif

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        rd_d       = rd_q;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        rvalid0_d  = 1'b0;
        rvalid1_d  = 1'b0;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
`ifndef ARB_FIXED_PRIO_EN
        last_d     = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    state_d    = ACCESS;
                    win_d      = win_sel;
                    rd_d       = win_sel ? !we1 : !we0;
                    mem_addr_d = win_sel ? addr1 : addr0;
                    mem_data_d = win_sel ? wdata1 : wdata0;
                    mem_we_d   = win_sel ? we1 : we0;
                    gnt0_d     = !win_sel;
                    gnt1_d     = win_sel;
`ifndef ARB_FIXED_PRIO_EN
                    last_d     = win_sel;
`endif
                end
            end
            ACCESS: state_d = RESP;
            RESP: begin
                // mem_out now reflects the address presented during ACCESS.
                state_d = IDLE;
                if (rd_q) begin
                    if (win_q) begin
                        rdata1_d  = mem_out;
                        rvalid1_d = 1'b1;
                    end else begin
                        rdata0_d  = mem_out;
                        rvalid0_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            win_q      <= 1'b0;
            rd_q       <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
`ifndef ARB_FIXED_PRIO_EN
            last_q     <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            rd_q       <= rd_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
`ifndef ARB_FIXED_PRIO_EN
            last_q     <= last_d;
`endif
        end
    end

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign rvalid0  = rvalid0_q;
    assign rvalid1  = rvalid1_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign mem_we   = mem_we_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural 1-cycle-latency memory.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [9:0]  addr0 = '0, addr1 = '0;
    logic [15:0] wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1, mem_we;
    logic [15:0] rdata0, rdata1, mem_data, mem_out;
    logic [9:0]  mem_addr;

    logic [15:0] mem [0:1023];

    int tests = 0;
    int fails = 0;
    int exp_gnt[$];
    int exp_rv_id[$];
    logic [15:0] exp_rv_data[$];

    always #5 clk = ~clk;

    mem_port_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(10)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
        .mem_out(mem_out)
    );

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_data;
        mem_out <= mem[mem_addr];
    end

    // Monitor: pops expectations whenever the DUT presents a grant or read response.
    always @(negedge clk) begin
        if (!reset) begin
            if (gnt0 || gnt1) begin
                tests++;
                if (gnt0 && gnt1) begin
                    fails++; $display("FAIL gnt_excl: both grants high, required one");
                end else if (exp_gnt.size() == 0) begin
                    fails++; $display("FAIL gnt_unexp: got gnt%0d, required none", gnt1 ? 1 : 0);
                end else begin
                    int e;
                    e = exp_gnt.pop_front();
                    if ((gnt1 ? 1 : 0) != e) begin
                        fails++; $display("FAIL gnt_id: got gnt%0d, required gnt%0d", gnt1 ? 1 : 0, e);
                    end
                end
            end
            if (rvalid0 || rvalid1) begin
                tests++;
                if (rvalid0 && rvalid1) begin
                    fails++; $display("FAIL rv_excl: both rvalid high, required one");
                end else if (exp_rv_id.size() == 0) begin
                    fails++; $display("FAIL rv_unexp: got rvalid%0d, required none", rvalid1 ? 1 : 0);
                end else begin
                    int e;
                    logic [15:0] d, a;
                    e = exp_rv_id.pop_front();
                    d = exp_rv_data.pop_front();
                    a = rvalid1 ? rdata1 : rdata0;
                    if ((rvalid1 ? 1 : 0) != e || a != d) begin
                        fails++;
                        $display("FAIL rv_data: got rvalid%0d data %h, required rvalid%0d data %h",
                                 rvalid1 ? 1 : 0, a, e, d);
                    end
                end
            end
            if (mem_we) begin
                tests++;
                if (!(gnt0 || gnt1)) begin
                    fails++; $display("FAIL mem_we_window: mem_we high outside ACCESS, required 0");
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++; $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic wait_gnt(input int id);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(posedge clk); #1;
            if (id == 0 ? gnt0 : gnt1) got = 1'b1;
        end
        if (!got) begin
            tests++; fails++;
            $display("FAIL gnt_timeout: got no gnt%0d, required gnt%0d", id, id);
        end
    endtask

    task automatic access(input int id, input logic we, input logic [9:0] a,
                          input logic [15:0] wd, input logic [15:0] rd_exp);
        exp_gnt.push_back(id);
        if (!we) begin exp_rv_id.push_back(id); exp_rv_data.push_back(rd_exp); end
        if (id == 0) begin req0 = 1; we0 = we; addr0 = a; wdata0 = wd; end
        else         begin req1 = 1; we1 = we; addr1 = a; wdata1 = wd; end
        wait_gnt(id);
        req0 = 0; req1 = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic tie_reads(input logic [9:0] a0, input logic [15:0] d0,
                             input logic [9:0] a1, input logic [15:0] d1);
        exp_gnt.push_back(0); exp_rv_id.push_back(0); exp_rv_data.push_back(d0);
        exp_gnt.push_back(1); exp_rv_id.push_back(1); exp_rv_data.push_back(d1);
        req0 = 1; we0 = 0; addr0 = a0;
        req1 = 1; we1 = 0; addr1 = a1;
        wait_gnt(0);
        req0 = 0;
        wait_gnt(1);
        req1 = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt, guard;
        // Requests held during reset must be ignored.
        req0 = 1; req1 = 1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt0", gnt0, 0);
        check("rst_gnt1", gnt1, 0);
        check("rst_rvalid0", rvalid0, 0);
        check("rst_rvalid1", rvalid1, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_data", mem_data, 0);
        check("rst_rdata0", rdata0, 0);
        check("rst_rdata1", rdata1, 0);
        req0 = 0; req1 = 0;
        reset = 0;
        @(posedge clk); #1;

        access(0, 1, 10'h000, 16'hdead, 16'h0);
        access(1, 1, 10'h001, 16'hbeaf, 16'h0);

        tie_reads(10'h000, 16'hdead, 10'h001, 16'hbeaf);

        // Both requesters hold read requests continuously.
`ifdef ARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) begin
            exp_gnt.push_back(0); exp_rv_id.push_back(0); exp_rv_data.push_back(16'hdead);
        end
`else
        for (int i = 0; i < 4; i++) begin
            exp_gnt.push_back(i % 2); exp_rv_id.push_back(i % 2);
            exp_rv_data.push_back((i % 2) ? 16'hbeaf : 16'hdead);
        end
`endif
        req0 = 1; we0 = 0; addr0 = 10'h000;
        req1 = 1; we1 = 0; addr1 = 10'h001;
        cnt = 0; guard = 0;
        while (cnt < 4 && guard < 40) begin
            @(posedge clk); #1;
            guard++;
            if (gnt0 || gnt1) cnt++;
        end
        check("hold_grant_count", cnt, 4);
        req0 = 0; req1 = 0;
        repeat (2) @(posedge clk);
        #1;

        access(1, 1, 10'h002, 16'h1234, 16'h0);
        access(0, 0, 10'h002, 16'h0, 16'h1234);
        check("rdata1_hold", rdata1, 16'hbeaf);

        access(1, 1, 10'h3ff, 16'hffff, 16'h0);
        access(1, 0, 10'h3ff, 16'h0, 16'hffff);

        // Reset lands on the RESP->IDLE edge of a requester-0 read.
        exp_gnt.push_back(0);
        req0 = 1; we0 = 0; addr0 = 10'h000;
        wait_gnt(0);
        req0 = 0;
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        check("rstresp_rvalid0", rvalid0, 0);
        check("rstresp_rdata0", rdata0, 0);
        check("rstresp_gnt0", gnt0, 0);
        @(posedge clk); #1;
        tie_reads(10'h002, 16'h1234, 10'h001, 16'hbeaf);

        repeat (4) @(posedge clk);
        #1;
        check("sb_gnt_empty", exp_gnt.size(), 0);
        check("sb_rv_empty", exp_rv_id.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
